// File: rtl/cpu_core_params.sv
// rtl/cpu_core_params.sv - CPU core shared bus types
package cpu_core_params;

  typedef logic [31:0] Address;
  typedef logic [31:0] CpuData;

endpackage

// File: rtl/sram_port_arbiter_params.sv
// rtl/sram_port_arbiter_params.sv - types shared by the SRAM port arbiter
package sram_port_arbiter_params;

  import cpu_core_params::*;

  // Which port owns the response arriving on sram_read_data next cycle.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_INST = 2'd1,
    OWNER_DATA = 2'd2
  } Owner;

  typedef logic [2:0] StarveCount;

  localparam StarveCount STARVE_MAX = 3'd7;

  typedef struct packed {
    logic       enabled;
    logic [3:0] write_strobe;
    Address     address;
    CpuData     write_data;
  } SramRequest;

endpackage

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port (instruction/data) arbiter onto one SRAM
//
// Purpose: grants one of the instruction or data ports to a single-ported
// SRAM each cycle, data first, with a starvation guard for instruction
// fetches. Read data returns one cycle after the grant to the owning port.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   inst_* / data_*              request inputs (enabled, write_strobe,
//                                address, write_data), grant output, read
//                                response (read_valid, read_data)
//   sram_*                       unified SRAM request outputs, read data input
module sram_port_arbiter
  import cpu_core_params::*;
  import sram_port_arbiter_params::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,

  input  logic       inst_enabled,
  input  logic [3:0] inst_write_strobe,
  input  Address     inst_address,
  input  CpuData     inst_write_data,
  output logic       inst_grant,
  output logic       inst_read_valid,
  output CpuData     inst_read_data,

  input  logic       data_enabled,
  input  logic [3:0] data_write_strobe,
  input  Address     data_address,
  input  CpuData     data_write_data,
  output logic       data_grant,
  output logic       data_read_valid,
  output CpuData     data_read_data,

  output logic       sram_enabled,
  output logic [3:0] sram_write_strobe,
  output Address     sram_address,
  output CpuData     sram_write_data,
  input  CpuData     sram_read_data
);

  localparam StarveCount LIMIT = StarveCount'(STARVE_LIMIT);

  Owner       owner_q, owner_d;
  StarveCount starve_q, starve_d;
  CpuData     inst_hold_q, inst_hold_d;
  CpuData     data_hold_q, data_hold_d;

  SramRequest inst_req, data_req, sram_req;
  logic       inst_wins, data_wins, inst_starved;

  always_comb begin
    inst_req = '{enabled: inst_enabled, write_strobe: inst_write_strobe,
                 address: inst_address, write_data: inst_write_data};
    data_req = '{enabled: data_enabled, write_strobe: data_write_strobe,
                 address: data_address, write_data: data_write_data};
  end

  // Data wins by default; a starved instruction request overrides it.
  always_comb begin
    inst_wins    = 1'b0;
    data_wins    = 1'b0;
    inst_starved = (starve_q >= LIMIT);
    if (!reset) begin
      if (data_enabled && !(inst_enabled && inst_starved)) begin
        data_wins = 1'b1;
      end else if (inst_enabled) begin
        inst_wins = 1'b1;
      end
    end
  end

  assign inst_grant = inst_wins;
  assign data_grant = data_wins;

  always_comb begin
    sram_req = '0;
    if (inst_wins) begin
      sram_req = inst_req;
    end else if (data_wins) begin
      sram_req = data_req;
    end
  end

  assign sram_enabled      = sram_req.enabled;
  assign sram_write_strobe = sram_req.write_strobe;
  assign sram_address      = sram_req.address;
  assign sram_write_data   = sram_req.write_data;

  // Only a granted read expects a response next cycle.
  always_comb begin
    owner_d = OWNER_NONE;
    if (inst_wins && (inst_write_strobe == 4'h0)) begin
      owner_d = OWNER_INST;
    end else if (data_wins && (data_write_strobe == 4'h0)) begin
      owner_d = OWNER_DATA;
    end
  end

  always_comb begin
    starve_d = '0;
    if (inst_enabled && !inst_wins) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : StarveCount'(starve_q + 3'd1);
    end
  end

  // A response still in flight when reset arrives is discarded.
  assign inst_read_valid = !reset && (owner_q == OWNER_INST);
  assign data_read_valid = !reset && (owner_q == OWNER_DATA);

  always_comb begin
    inst_hold_d = inst_read_valid ? sram_read_data : inst_hold_q;
    data_hold_d = data_read_valid ? sram_read_data : data_hold_q;
  end

  assign inst_read_data = reset ? '0 : inst_hold_d;
  assign data_read_data = reset ? '0 : data_hold_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWNER_NONE;
      starve_q    <= '0;
      inst_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: the number of consecutive cycles a waiting instruction request may lose to data before it is forced to win; legal range 1..7.
REQ-002 clock  input  1  The single clock; all state updates on posedge clock.
REQ-003 reset  input  1  Reset, synchronous, active-high.
REQ-004 inst_enabled  input  1  Instruction port request valid.
REQ-005 inst_write_strobe  input  4  Instruction port byte write strobes; 4'h0 means read.
REQ-006 inst_address  input  32  Instruction port byte address, type cpu_core_params::Address.
REQ-007 inst_write_data  input  32  Instruction port write data, type cpu_core_params::CpuData.
REQ-008 inst_grant  output  1  Instruction request issued to SRAM this cycle.
REQ-009 inst_read_valid  output  1  Instruction read data returned this cycle.
REQ-010 inst_read_data  output  32  Instruction read data, held between responses.
REQ-011 data_enabled, data_write_strobe, data_address, data_write_data, data_grant, data_read_valid, data_read_data: same directions, widths and meanings as REQ-004..REQ-010, for the data port.
REQ-012 sram_enabled  output  1  Unified SRAM enable.
REQ-013 sram_write_strobe  output  4  Unified SRAM byte write strobes.
REQ-014 sram_address  output  32  Unified SRAM address.
REQ-015 sram_write_data  output  32  Unified SRAM write data.
REQ-016 sram_read_data  input  32  Unified SRAM read data; valid one cycle after a read is enabled.

Function
REQ-017 Arbitration is combinational within a cycle; at most one of inst_grant or data_grant is high, and it is high only when the matching _enabled is high.
REQ-018 Default priority: data wins when both ports request.
REQ-019 The starve counter holds 3 bits and saturates; it increments when inst_enabled is high and inst_grant is low, and clears when inst_grant is high or inst_enabled is low.
REQ-020 When starve counter >= STARVE_LIMIT and both ports request, the instruction port wins; the counter then clears.
REQ-021 The SRAM outputs mux the fields of the granted port; when no port is granted, sram_enabled=0, sram_write_strobe=0, and address/write data=0.
REQ-022 A port that is not granted holds its request unchanged; the arbiter keeps no request copies.
REQ-023 The owner register (NONE/INST/DATA) records the winner of a granted read (strobe==0); a granted write or an idle cycle loads NONE.
REQ-024 Read latency is exactly 1 cycle: owner==X causes X_read_valid=1 for one cycle, and X_read_data captures sram_read_data in that cycle (combinational pass-through plus a hold register).
REQ-025 Outside its response cycle, X_read_data shows its hold register, i.e. the last data returned to that port; it is never corrupted by the other port's responses.
REQ-026 Writes produce no read_valid on either port.
REQ-027 Back-to-back grants are supported: a new grant and the previous grant's response may occur in the same cycle.

Reset
REQ-028 In a reset cycle, all grants, sram_enabled and sram_write_strobe are forced 0, regardless of inputs.
REQ-029 After reset: owner=NONE, starve counter=0, both read-data hold registers=32'h0, both read_valid=0; a response pending when reset asserts is dropped.

Structure
REQ-030 Package sram_port_arbiter_params holds the owner enum (OWNER_NONE, OWNER_INST, OWNER_DATA), the StarveCount typedef (3 bits) and a SramRequest struct {enabled, write_strobe, address, write_data}; Address and CpuData come from cpu_core_params.
REQ-031 There is no sub-module; the block has a single always_ff for state plus combinational grant/mux logic.

Verification
REQ-032 Inst-only read at 32'hbfc00000 -> inst_grant=1 and sram_address=32'hbfc00000 the same cycle; next cycle inst_read_valid=1 and inst_read_data=sram_read_data.
REQ-033 Both ports request continuously, STARVE_LIMIT=4 -> data granted 4 cycles, instruction granted on the 5th; the pattern repeats.
REQ-034 Data write with strobe 4'hf at 32'h1000 while inst reads -> data_grant=1, no read_valid next cycle; inst granted the following cycle.
REQ-035 Inst reads 32'h11111111, then data reads 32'h22222222 back-to-back -> inst_read_data stays 32'h11111111 during and after the data response.
REQ-036 Reset asserted in the cycle after a read grant -> no read_valid, all outputs 0, hold registers 0, counter 0.
